// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
package clock_divider_pkg;

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  localparam int MIN_DIV   = 2;
  localparam int MAX_CNT_W = 32;

  // High time of a period, one bit wider than any supported divisor so D+1 cannot overflow.
  function automatic logic [MAX_CNT_W:0] half_period(input logic [MAX_CNT_W-1:0] d);
    return ({1'b0, d} + 1'b1) >> 1;
  endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: shadow divisor, period counter, divided clock, period strobe and error flag.
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             div_err
);

  localparam int WIDE = MAX_CNT_W + 1;

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] d_reg, d_nxt;
  logic             clk_nxt, tick_nxt, err_nxt;
  logic             div_ok, wrap;
  logic [WIDE-1:0]  cnt_inc, high_len;

  assign div_ok   = (div >= CNT_W'(MIN_DIV));
  assign wrap     = (cnt == d_reg - 1'b1);
  assign cnt_inc  = WIDE'(cnt) + 1'b1;
  assign high_len = half_period(MAX_CNT_W'(d_reg));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= CH_IDLE;
      cnt     <= '0;
      d_reg   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      div_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      d_reg   <= d_nxt;
      clk_out <= clk_nxt;
      tick    <= tick_nxt;
      div_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d_reg;
    clk_nxt   = clk_out;
    tick_nxt  = 1'b0;
    err_nxt   = div_err;
    unique case (state)
      CH_IDLE: begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
        if (en) begin
          if (div_ok) begin
            d_nxt     = div;
            clk_nxt   = 1'b1;
            tick_nxt  = 1'b1;
            err_nxt   = 1'b0;
            state_nxt = CH_RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      CH_RUN: begin
        // A disabled channel only stops at its period end; sync never cuts a stopping period short.
        if (wrap && !en) begin
          state_nxt = CH_IDLE;
          cnt_nxt   = '0;
          clk_nxt   = 1'b0;
        end else if (en && (wrap || sync)) begin
          cnt_nxt  = '0;
          clk_nxt  = 1'b1;
          tick_nxt = 1'b1;
          if (div_ok) begin
            d_nxt   = div;
            err_nxt = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_inc[CNT_W-1:0];
          clk_nxt = (cnt_inc < high_len);
        end
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider: independent channels sharing reset and phase-align.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] div,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_in (clk_in),
      .rst    (rst),
      .en     (en[i]),
      .div    (div[i*CNT_W +: CNT_W]),
      .sync   (sync),
      .clk_out(clk_out[i]),
      .tick   (tick[i]),
      .div_err(div_err[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi (2 channels, 16-bit divisors).
module tb_clock_divider_multi;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [31:0] div;
  logic        sync;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [1:0]  div_err;

  int n_checks = 0;
  int n_pass   = 0;

  clock_divider_multi #(
    .NUM_CH(2),
    .CNT_W (16)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .div    (div),
    .sync   (sync),
    .clk_out(clk_out),
    .tick   (tick),
    .div_err(div_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] e, input logic [15:0] d0,
                               input logic [15:0] d1, input logic s);
    rst  = r;
    en   = e;
    div  = {d1, d0};
    sync = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Steps n cycles of channel ch, period position starting at k0, checking against a D-cycle waveform.
  task automatic checkPattern(input string tag, input int ch, input int d, input int k0, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      step();
      k = (k0 + i) % d;
      checkOutput($sformatf("%s clk k=%0d", tag, k), 32'(clk_out[ch]), 32'(k < (d + 1) / 2));
      checkOutput($sformatf("%s tick k=%0d", tag, k), 32'(tick[ch]), 32'(k == 0));
    end
  endtask

  initial begin
    int highs;
    int ticks;

    applyStimulus(1'b1, 2'b00, 16'd0, 16'd0, 1'b0);
    step();
    checkOutput("reset clk_out", 32'(clk_out), 32'd0);
    checkOutput("reset tick", 32'(tick), 32'd0);
    checkOutput("reset div_err", 32'(div_err), 32'd0);

    applyStimulus(1'b0, 2'b01, 16'd4, 16'd0, 1'b0);
    checkPattern("div4", 0, 4, 0, 8);

    applyStimulus(1'b0, 2'b01, 16'd5, 16'd0, 1'b0);
    checkPattern("div5", 0, 5, 0, 10);

    applyStimulus(1'b0, 2'b01, 16'd2, 16'd0, 1'b0);
    checkPattern("div2", 0, 2, 0, 6);

    // Maximum divisor: one full period, counting high cycles and strobes.
    applyStimulus(1'b0, 2'b01, 16'd65535, 16'd0, 1'b0);
    step();
    checkOutput("max start clk", 32'(clk_out[0]), 32'd1);
    checkOutput("max start tick", 32'(tick[0]), 32'd1);
    applyStimulus(1'b0, 2'b01, 16'd4, 16'd0, 1'b0);
    highs = 1;
    ticks = 0;
    for (int i = 1; i < 65535; i++) begin
      step();
      highs += int'(clk_out[0]);
      ticks += int'(tick[0]);
    end
    checkOutput("max high count", 32'(highs), 32'd32768);
    checkOutput("max extra ticks", 32'(ticks), 32'd0);
    step();
    checkOutput("max wrap tick", 32'(tick[0]), 32'd1);
    checkOutput("max wrap clk", 32'(clk_out[0]), 32'd1);

    // Divisor change mid-period: current 4-cycle period completes first.
    step();
    applyStimulus(1'b0, 2'b01, 16'd6, 16'd0, 1'b0);
    checkPattern("reload old", 0, 4, 2, 2);
    checkPattern("reload div6", 0, 6, 0, 12);

    // Disable mid-period: period still runs to its end, then silence.
    applyStimulus(1'b0, 2'b01, 16'd8, 16'd0, 1'b0);
    checkPattern("stop start", 0, 8, 0, 2);
    applyStimulus(1'b0, 2'b00, 16'd8, 16'd0, 1'b0);
    checkPattern("stop tail", 0, 8, 2, 6);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("stopped clk", 32'(clk_out[0]), 32'd0);
      checkOutput("stopped tick", 32'(tick[0]), 32'd0);
    end

    // Phase align: ch0 D=8 at cnt=3, ch1 D=3 at cnt=1.
    applyStimulus(1'b0, 2'b01, 16'd8, 16'd0, 1'b0);
    step();
    step();
    applyStimulus(1'b0, 2'b11, 16'd8, 16'd3, 1'b0);
    step();
    step();
    checkOutput("pre-sync clk", 32'(clk_out), 32'b11);
    applyStimulus(1'b0, 2'b11, 16'd8, 16'd3, 1'b1);
    step();
    checkOutput("sync clk", 32'(clk_out), 32'b11);
    checkOutput("sync tick", 32'(tick), 32'b11);
    applyStimulus(1'b0, 2'b11, 16'd8, 16'd3, 1'b0);
    step();
    checkOutput("sync k1 clk", 32'(clk_out), 32'b11);
    checkOutput("sync k1 tick", 32'(tick), 32'b00);
    step();
    checkOutput("sync k2 clk", 32'(clk_out), 32'b01);

    // Reset mid-run clears everything on the next edge.
    applyStimulus(1'b1, 2'b11, 16'd8, 16'd3, 1'b0);
    step();
    checkOutput("midrun rst clk", 32'(clk_out), 32'd0);
    checkOutput("midrun rst tick", 32'(tick), 32'd0);
    checkOutput("midrun rst err", 32'(div_err), 32'd0);

    // Illegal divisor while idle keeps the channel idle and flags an error.
    applyStimulus(1'b0, 2'b01, 16'd1, 16'd0, 1'b0);
    step();
    checkOutput("bad idle err", 32'(div_err[0]), 32'd1);
    checkOutput("bad idle clk", 32'(clk_out[0]), 32'd0);
    step();
    checkOutput("bad idle tick", 32'(tick[0]), 32'd0);
    applyStimulus(1'b0, 2'b01, 16'd4, 16'd0, 1'b0);
    step();
    checkOutput("good start clk", 32'(clk_out[0]), 32'd1);
    checkOutput("good start tick", 32'(tick[0]), 32'd1);
    checkOutput("good start err", 32'(div_err[0]), 32'd0);

    // Illegal divisor at a wrap keeps the old period and sets the flag.
    applyStimulus(1'b0, 2'b01, 16'd0, 16'd0, 1'b0);
    checkPattern("bad wrap pre", 0, 4, 1, 3);
    checkPattern("bad wrap run", 0, 4, 0, 2);
    checkOutput("bad wrap err", 32'(div_err[0]), 32'd1);
    applyStimulus(1'b0, 2'b01, 16'd4, 16'd0, 1'b0);
    checkPattern("recover pre", 0, 4, 2, 2);
    step();
    checkOutput("recover err", 32'(div_err[0]), 32'd0);
    checkOutput("recover tick", 32'(tick[0]), 32'd1);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
